// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the two-port multiplier arbiter.
// mul_op_t is the payload carried through the stage-1 register.
package mul_arb_pkg;
  localparam int REQ_COUNT = 2;
  localparam int WORD_SIZE = 18;
  localparam int MAX_SHIFT = 18;
  localparam int SHIFT_W   = 5;

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [SHIFT_W-1:0]   shift_t;

  typedef struct packed {
    word_t  r0;
    word_t  r1;
    shift_t shift;
    logic   signx;
    logic   signy;
    logic   id;
  } mul_op_t;

  // Requests beyond MAX_SHIFT behave exactly like MAX_SHIFT.
  function automatic shift_t clamp_shift(input shift_t sh);
    return (sh > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : sh;
  endfunction
endpackage

// File: rtl/mul_arbiter_if.sv
// Request/response bundle between the two requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface mul_arbiter_if;
  import mul_arb_pkg::*;

  logic [REQ_COUNT-1:0] req_valid;
  logic [REQ_COUNT-1:0] req_ready;
  word_t                req_r0_0;
  word_t                req_r0_1;
  word_t                req_r1_0;
  word_t                req_r1_1;
  shift_t               req_shift_0;
  shift_t               req_shift_1;
  logic [REQ_COUNT-1:0] req_signx;
  logic [REQ_COUNT-1:0] req_signy;
  logic [REQ_COUNT-1:0] rsp_valid;
  word_t                rsp_res;
  logic                 busy;

  modport master (
    output req_valid, req_r0_0, req_r0_1, req_r1_0, req_r1_1,
           req_shift_0, req_shift_1, req_signx, req_signy,
    input  req_ready, rsp_valid, rsp_res, busy
  );

  modport slave (
    input  req_valid, req_r0_0, req_r0_1, req_r1_0, req_r1_1,
           req_shift_0, req_shift_1, req_signx, req_signy,
    output req_ready, rsp_valid, rsp_res, busy
  );
endinterface

// File: rtl/mul_arbiter_mulxx.sv
// Combinational WORD_SIZE x WORD_SIZE multiplier with per-operand signedness,
// right shift of the full product, low WORD_SIZE bits returned.
module mulxx #(
  parameter int WORD_SIZE = 18,
  parameter int SHIFT_W   = 5
) (
  input  logic [WORD_SIZE-1:0] a_i,
  input  logic [WORD_SIZE-1:0] b_i,
  input  logic [SHIFT_W-1:0]   shift_i,
  input  logic                 signx_i,
  input  logic                 signy_i,
  output logic [WORD_SIZE-1:0] res_o
);
  // Two guard bits keep mixed signed x unsigned products exact.
  localparam int PW = 2*WORD_SIZE + 2;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;

  assign a_ext = signed'({{(PW-WORD_SIZE){signx_i & a_i[WORD_SIZE-1]}}, a_i});
  assign b_ext = signed'({{(PW-WORD_SIZE){signy_i & b_i[WORD_SIZE-1]}}, b_i});
  assign prod  = a_ext * b_ext;
  assign res_o = WORD_SIZE'(prod >>> shift_i);
endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one mulxx between two requesters through a
// two-stage pipeline; responses pulse on the issuing port two cycles later.
module mul_arbiter
  import mul_arb_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  mul_arbiter_if.slave  bus
);
  logic                 last_grant_q, last_grant_d;
  mul_op_t              s1_q, s1_d;
  logic                 s1_valid_q, s1_valid_d;
  word_t                s2_res_q, s2_res_d;
  logic                 s2_id_q, s2_id_d;
  logic                 s2_valid_q, s2_valid_d;

  logic [REQ_COUNT-1:0] grant;
  logic                 grant_id;
  logic                 xfer;
  mul_op_t              req_op;
  word_t                mul_res;

  // Grant is held off entirely while reset is low.
  always_comb begin
    grant = '0;
    if (reset) begin
      if (bus.req_valid[0] && (!bus.req_valid[1] || last_grant_q))
        grant[0] = 1'b1;
      else if (bus.req_valid[1])
        grant[1] = 1'b1;
    end
  end

  assign xfer     = |grant;
  assign grant_id = grant[1];

  always_comb begin
    req_op.r0    = grant_id ? bus.req_r0_1 : bus.req_r0_0;
    req_op.r1    = grant_id ? bus.req_r1_1 : bus.req_r1_0;
    req_op.shift = clamp_shift(grant_id ? bus.req_shift_1 : bus.req_shift_0);
    req_op.signx = bus.req_signx[grant_id];
    req_op.signy = bus.req_signy[grant_id];
    req_op.id    = grant_id;
  end

  mulxx #(
    .WORD_SIZE (WORD_SIZE),
    .SHIFT_W   (SHIFT_W)
  ) u_mulxx (
    .a_i     (s1_q.r0),
    .b_i     (s1_q.r1),
    .shift_i (s1_q.shift),
    .signx_i (s1_q.signx),
    .signy_i (s1_q.signy),
    .res_o   (mul_res)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    s1_d         = s1_q;
    s1_valid_d   = xfer;
    if (xfer) begin
      s1_d         = req_op;
      last_grant_d = grant_id;
    end
    s2_valid_d = s1_valid_q;
    s2_id_d    = s1_q.id;
    s2_res_d   = s1_valid_q ? mul_res : s2_res_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
      s1_q         <= '0;
      s1_valid_q   <= 1'b0;
      s2_res_q     <= '0;
      s2_id_q      <= 1'b0;
      s2_valid_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      s1_q         <= s1_d;
      s1_valid_q   <= s1_valid_d;
      s2_res_q     <= s2_res_d;
      s2_id_q      <= s2_id_d;
      s2_valid_q   <= s2_valid_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = s2_valid_q ? (s2_id_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_res   = s2_res_q;
  assign bus.busy      = s1_valid_q | s2_valid_q;
endmodule
